// File: rtl/lht_update_scheduler.sv
// Local history table port scheduler: 0-cycle lookups win, buffered outcome updates fill idle cycles, forced issue on full/starve.
// Optional build macro LHT_HAZARD_STALL_EN: stall lookups that hit a pending update's index; backpressure via upd_ready when FIFO full.
module lht_update_scheduler #(
    parameter int INDEX_LEN  = 7,
    parameter int DEPTH      = 4,
    parameter int STARVE_MAX = 8
) (
    input  logic                   clk,
    input  logic                   reset,
    input  logic                   lk_req,
    input  logic [INDEX_LEN-1:0]   lk_pc,
    output logic                   lk_gnt,
    input  logic                   upd_valid,
    input  logic [INDEX_LEN-1:0]   upd_pc,
    input  logic                   upd_taken,
    output logic                   upd_ready,
    output logic [INDEX_LEN-1:0]   tbl_pc_bits,
    output logic                   tbl_taken,
    output logic                   tbl_read_only,
    output logic [$clog2(DEPTH):0] pending
);

    localparam int PW = $clog2(DEPTH);
    localparam int CW = PW + 1;
    localparam int SW = $clog2(STARVE_MAX + 1);

    typedef enum logic {
        ST_LOOKUP = 1'b0,
        ST_FORCE  = 1'b1
    } state_t;

    state_t               r_state;
    logic [PW-1:0]        r_wptr;
    logic [PW-1:0]        r_rptr;
    logic [CW-1:0]        r_cnt;
    logic [SW-1:0]        r_starve;
    logic [INDEX_LEN-1:0] r_fifo_pc [DEPTH];
    logic                 r_fifo_tk [DEPTH];

    logic                 w_empty;
    logic                 w_full;
    logic                 w_push;
    logic                 w_grant;
    logic                 w_issue;
    logic                 w_hazard;
    logic [CW-1:0]        w_cnt_nxt;
    logic [SW-1:0]        w_starve_nxt;
    logic [INDEX_LEN-1:0] w_head_pc;
    logic                 w_head_tk;

    assign w_empty   = (r_cnt == '0);
    assign w_full    = (r_cnt == CW'(DEPTH));
    assign w_push    = upd_valid && !w_full;
    assign w_head_pc = r_fifo_pc[r_rptr];
    assign w_head_tk = r_fifo_tk[r_rptr];

`ifdef LHT_HAZARD_STALL_EN
    // An entry is live when its distance from the read pointer is below the occupancy.
    always_comb begin
        logic [PW-1:0] w_off;
        w_hazard = 1'b0;
        w_off    = '0;
        for (int i = 0; i < DEPTH; i++) begin
            w_off = PW'(i) - r_rptr;
            if (({1'b0, w_off} < r_cnt) && (r_fifo_pc[i] == lk_pc) && lk_req)
                w_hazard = 1'b1;
        end
    end
`else
    assign w_hazard = 1'b0;
`endif

    always_comb begin
        w_grant = 1'b0;
        w_issue = 1'b0;
        if (r_state == ST_LOOKUP) begin
            w_grant = lk_req && !w_hazard;
            w_issue = !w_grant && !w_empty;
        end else begin
            w_issue = !w_empty;
        end
    end

    always_comb begin
        w_cnt_nxt = r_cnt;
        case ({w_push, w_issue})
            2'b10:   w_cnt_nxt = r_cnt + CW'(1);
            2'b01:   w_cnt_nxt = r_cnt - CW'(1);
            default: w_cnt_nxt = r_cnt;
        endcase
    end

    // A grant with a non-empty FIFO implies no pop, so a saturated count always has work to force.
    always_comb begin
        w_starve_nxt = r_starve;
        if (w_issue || w_empty)
            w_starve_nxt = '0;
        else if (w_grant && (r_starve != SW'(STARVE_MAX)))
            w_starve_nxt = r_starve + SW'(1);
    end

    assign lk_gnt        = w_grant;
    assign upd_ready     = !w_full;
    assign tbl_read_only = !w_issue;
    assign tbl_pc_bits   = w_issue ? w_head_pc : lk_pc;
    assign tbl_taken     = w_issue && w_head_tk;
    assign pending       = r_cnt;

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            r_state  <= ST_LOOKUP;
            r_wptr   <= '0;
            r_rptr   <= '0;
            r_cnt    <= '0;
            r_starve <= '0;
        end else begin
            if (w_push)
                r_wptr <= r_wptr + PW'(1);
            if (w_issue)
                r_rptr <= r_rptr + PW'(1);
            r_cnt    <= w_cnt_nxt;
            r_starve <= w_starve_nxt;
            case (r_state)
                ST_LOOKUP: begin
                    if ((w_cnt_nxt == CW'(DEPTH)) || (w_starve_nxt == SW'(STARVE_MAX)))
                        r_state <= ST_FORCE;
                end
                default: r_state <= ST_LOOKUP;
            endcase
        end
    end

    // Storage needs no reset: occupancy alone decides which entries are meaningful.
    always_ff @(posedge clk) begin
        if (w_push) begin
            r_fifo_pc[r_wptr] <= upd_pc;
            r_fifo_tk[r_wptr] <= upd_taken;
        end
    end

endmodule

// File: tb/tb_lht_update_scheduler.sv
// Directed bench for lht_update_scheduler (default parameters: DEPTH=4, STARVE_MAX=8).
module tb_lht_update_scheduler;

    logic       clk = 1'b0;
    logic       reset;
    logic       lk_req;
    logic [6:0] lk_pc;
    logic       lk_gnt;
    logic       upd_valid;
    logic [6:0] upd_pc;
    logic       upd_taken;
    logic       upd_ready;
    logic [6:0] tbl_pc_bits;
    logic       tbl_taken;
    logic       tbl_read_only;
    logic [2:0] pending;

    int checks = 0;
    int errors = 0;

    lht_update_scheduler dut (
        .clk          (clk),
        .reset        (reset),
        .lk_req       (lk_req),
        .lk_pc        (lk_pc),
        .lk_gnt       (lk_gnt),
        .upd_valid    (upd_valid),
        .upd_pc       (upd_pc),
        .upd_taken    (upd_taken),
        .upd_ready    (upd_ready),
        .tbl_pc_bits  (tbl_pc_bits),
        .tbl_taken    (tbl_taken),
        .tbl_read_only(tbl_read_only),
        .pending      (pending)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #2;
    endtask

    task automatic push(input logic [6:0] pc, input logic tk);
        upd_valid = 1'b1;
        upd_pc    = pc;
        upd_taken = tk;
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog observed=timeout expected=finish");
        $fatal(1, "watchdog");
    end

    initial begin
        reset = 1'b0; lk_req = 1'b0; lk_pc = '0;
        upd_valid = 1'b0; upd_pc = '0; upd_taken = 1'b0;
        #1;
        chk("rst_pending", pending, 0);
        chk("rst_upd_ready", upd_ready, 1);
        chk("rst_ro", tbl_read_only, 1);
        chk("rst_taken", tbl_taken, 0);
        chk("rst_gnt", lk_gnt, 0);
        #10 reset = 1'b1;
        tick();

        // single update drains in the next idle cycle
        push(7'd5, 1'b1); #1;
        chk("t1_ready", upd_ready, 1);
        chk("t1_idle_ro", tbl_read_only, 1);
        tick();
        upd_valid = 1'b0; #1;
        chk("t1_ro", tbl_read_only, 0);
        chk("t1_pc", tbl_pc_bits, 5);
        chk("t1_taken", tbl_taken, 1);
        chk("t1_pending", pending, 1);
        chk("t1_ready2", upd_ready, 1);
        tick(); #1;
        chk("t1_pending0", pending, 0);
        chk("t1_ro_end", tbl_read_only, 1);

        // starvation forcing with continuous lookups
        lk_req = 1'b1; lk_pc = 7'd33;
        for (int k = 1; k <= 3; k++) begin
            push(7'(k), k[0]); #1;
            chk("t2_push_gnt", lk_gnt, 1);
            tick();
        end
        upd_valid = 1'b0;
        for (int k = 0; k < 6; k++) begin
            #1;
            chk("t2_gnt", lk_gnt, 1);
            chk("t2_lk_pc", tbl_pc_bits, 33);
            tick();
        end
        #1;
        chk("t2_force_gnt", lk_gnt, 0);
        chk("t2_force_ro", tbl_read_only, 0);
        chk("t2_force_pc", tbl_pc_bits, 1);
        chk("t2_force_taken", tbl_taken, 1);
        chk("t2_force_pending", pending, 3);
        tick();
        for (int k = 0; k < 8; k++) begin
            #1;
            chk("t2_regnt", lk_gnt, 1);
            tick();
        end
        #1;
        chk("t2_force2_gnt", lk_gnt, 0);
        chk("t2_force2_pc", tbl_pc_bits, 2);
        chk("t2_force2_taken", tbl_taken, 0);
        tick();
        lk_req = 1'b0; #1;
        chk("t2_drain_pc", tbl_pc_bits, 3);
        chk("t2_drain_ro", tbl_read_only, 0);
        tick(); #1;
        chk("t2_empty", pending, 0);

        // full FIFO forces and refuses
        lk_req = 1'b1;
        for (int k = 0; k < 4; k++) begin
            push(7'(20 + k), 1'b0); #1;
            chk("t3_ready", upd_ready, 1);
            chk("t3_gnt", lk_gnt, 1);
            tick();
        end
        push(7'd24, 1'b1); #1;
        chk("t3_full_pending", pending, 4);
        chk("t3_full_ready", upd_ready, 0);
        chk("t3_full_gnt", lk_gnt, 0);
        chk("t3_full_ro", tbl_read_only, 0);
        chk("t3_full_pc", tbl_pc_bits, 20);
        tick();
        upd_valid = 1'b0; #1;
        chk("t3_after_pending", pending, 3);
        chk("t3_after_ready", upd_ready, 1);
        chk("t3_after_gnt", lk_gnt, 1);
        tick();
        lk_req = 1'b0;
        for (int k = 1; k < 4; k++) begin
            #1;
            chk("t3_drain_pc", tbl_pc_bits, 20 + k);
            chk("t3_drain_ro", tbl_read_only, 0);
            tick();
        end
        #1;
        chk("t3_empty", pending, 0);

        // same-index ordering
        push(7'd9, 1'b1); #1;
        chk("t4_idle_ro", tbl_read_only, 1);
        tick();
        push(7'd9, 1'b0); #1;
        chk("t4_w1_ro", tbl_read_only, 0);
        chk("t4_w1_pc", tbl_pc_bits, 9);
        chk("t4_w1_taken", tbl_taken, 1);
        tick();
        push(7'd9, 1'b1); #1;
        chk("t4_w2_ro", tbl_read_only, 0);
        chk("t4_w2_taken", tbl_taken, 0);
        tick();
        upd_valid = 1'b0; #1;
        chk("t4_w3_ro", tbl_read_only, 0);
        chk("t4_w3_pc", tbl_pc_bits, 9);
        chk("t4_w3_taken", tbl_taken, 1);
        tick(); #1;
        chk("t4_empty", pending, 0);
        chk("t4_end_ro", tbl_read_only, 1);

        // asynchronous reset mid-drain
        lk_req = 1'b1; lk_pc = 7'd40;
        for (int k = 0; k < 3; k++) begin
            push(7'(50 + k), 1'b1);
            tick();
        end
        upd_valid = 1'b0; lk_req = 1'b0; #1;
        chk("t5_pre_pending", pending, 3);
        chk("t5_pre_ro", tbl_read_only, 0);
        #1 reset = 1'b0; #1;
        chk("t5_rst_pending", pending, 0);
        chk("t5_rst_ready", upd_ready, 1);
        chk("t5_rst_ro", tbl_read_only, 1);
        chk("t5_rst_taken", tbl_taken, 0);
        tick();
        reset = 1'b1;
        for (int k = 0; k < 3; k++) begin
            #1;
            chk("t5_post_ro", tbl_read_only, 1);
            chk("t5_post_pending", pending, 0);
            tick();
        end

        // lookup hitting a pending update's index
        lk_req = 1'b1; lk_pc = 7'd7;
        push(7'd12, 1'b1); #1;
        chk("t6_push_gnt", lk_gnt, 1);
        tick();
        upd_valid = 1'b0; lk_pc = 7'd12; #1;
`ifdef LHT_HAZARD_STALL_EN
        chk("t6_c1_gnt", lk_gnt, 0);
        chk("t6_c1_ro", tbl_read_only, 0);
        chk("t6_c1_pc", tbl_pc_bits, 12);
        tick(); #1;
        chk("t6_c2_gnt", lk_gnt, 1);
        chk("t6_c2_ro", tbl_read_only, 1);
        chk("t6_c2_pending", pending, 0);
`else
        chk("t6_c1_gnt", lk_gnt, 1);
        chk("t6_c1_ro", tbl_read_only, 1);
        chk("t6_c1_pc", tbl_pc_bits, 12);
        chk("t6_c1_pending", pending, 1);
        tick();
        lk_req = 1'b0; #1;
        chk("t6_drain_pc", tbl_pc_bits, 12);
        chk("t6_drain_ro", tbl_read_only, 0);
`endif
        lk_req = 1'b0;
        tick();

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

// File: doc/lht_update_scheduler.md
# lht_update_scheduler

Sequences all accesses to the local history table, whose single `pc_bits` index port is shared between fetch-stage lookups and execute-stage outcome updates. Fetch lookups have priority. Resolved branch outcomes are buffered in an internal FIFO and shifted into the table in cycles that fetch leaves free. When the FIFO fills, or when fetch has starved it for too long, one update is forced through. The block sits between fetch/execute and the table, and drives the table's `pc_bits`, `taken_not_taken` and `read_only` inputs.

## Interface
- `INDEX_LEN`, 7: table index width; must match the table.
- `DEPTH`, 4: update FIFO entries; power of 2, ≥2.
- `STARVE_MAX`, 8: consecutive lookup-won cycles with a non-empty FIFO before one update is forced; ≥1.
- `clk` in 1: clock; all state updates on the rising edge.
- `reset` in 1: asynchronous, active-low reset.
- `lk_req` in 1: fetch requests a lookup this cycle.
- `lk_pc` in INDEX_LEN: lookup index.
- `lk_gnt` out 1: lookup granted; the table's `history` is valid this same cycle.
- `upd_valid` in 1: execute offers a resolved branch outcome.
- `upd_pc` in INDEX_LEN: index of the resolved branch.
- `upd_taken` in 1: 1 = taken.
- `upd_ready` out 1: FIFO accepts; transfer occurs when `upd_valid & upd_ready` at the edge.
- `tbl_pc_bits` out INDEX_LEN: to table `pc_bits`.
- `tbl_taken` out 1: to table `taken_not_taken`.
- `tbl_read_only` out 1: to table `read_only`; 0 only in an update-issue cycle.
- `pending` out $clog2(DEPTH)+1: FIFO occupancy.

## Operation
- The FIFO holds {pc, taken}, with read/write pointers of $clog2(DEPTH) bits that wrap modulo DEPTH. The occupancy counter is one bit wider.
- `upd_ready = (pending != DEPTH)`. There is no same-cycle pass-through: a full FIFO refuses even when it pops that cycle.
- The arbiter has two states, LOOKUP and FORCE.
  - LOOKUP:
    - If `lk_req` is high, grant the lookup.
    - Otherwise, if the FIFO is non-empty, issue the head entry.
    - Otherwise, idle: `tbl_read_only=1`, `tbl_pc_bits=lk_pc`.
  - FORCE: issue the head entry, hold `lk_gnt=0` regardless of `lk_req`, then return to LOOKUP.
- LOOKUP→FORCE at the edge where either condition holds:
  - `pending==DEPTH` (including after that edge's push/pop), or
  - `starve_cnt==STARVE_MAX`.
- `starve_cnt` behaviour:
  - Increments, saturating, on each edge where the lookup is granted while `pending!=0`.
  - Clears on any update issue, and whenever `pending==0`.
  - Width is $clog2(STARVE_MAX+1).
- Update issue cycle:
  - `tbl_pc_bits=head.pc`, `tbl_taken=head.taken`, `tbl_read_only=0`.
  - The table shifts in the outcome at the edge, and the head is popped at the same edge.
- Lookup cycle: `tbl_pc_bits=lk_pc`, `tbl_read_only=1`, `tbl_taken=0`.
- Simultaneous push and pop leaves `pending` unchanged, and both pointers advance.
- Updates to the same index are applied in arrival order. FIFO order is never bypassed.

## Timing
- `lk_gnt`, `upd_ready` and the `tbl_*` outputs are combinational from registered state and the current inputs. No register sits on the path from `lk_pc`/`lk_req` to `tbl_pc_bits`.
- Lookup latency is 0: the history is valid in the grant cycle.
- Update latency: accepted at edge N; the earliest table write is at edge N+1, when the entry is at the head and the port is free.
- A stalled lookup (`lk_gnt=0`) must be held by fetch. The worst-case stall is 1 cycle per forced issue.
- Reset, asserted at any time, forces:
  - FIFO cleared and buffered updates discarded, `pending=0`.
  - State LOOKUP, `starve_cnt=0`.
  - Outputs: `upd_ready=1`, `tbl_read_only=1`, `tbl_taken=0`.
- Table contents are not touched by this block's reset.

## Configuration
- `LHT_HAZARD_STALL_EN` defined:
  - A lookup whose `lk_pc` matches any valid FIFO entry's pc is not granted (`lk_gnt=0`).
  - The arbiter issues the head that cycle instead, so the lookup proceeds only once all older updates to that index are in the table.
  - `starve_cnt` is unaffected by these stalls.
- Not defined: lookups are never stalled by pending updates and may return stale history. The per-entry comparators are not built.

## Test plan
- Reset, then `lk_req=0`, push {pc=5, taken=1}:
  - `upd_ready=1` throughout.
  - The next cycle shows `tbl_read_only=0`, `tbl_pc_bits=5`, `tbl_taken=1`.
  - `pending` returns to 0.
- `lk_req=1` on every cycle with 3 pushes, STARVE_MAX=8:
  - `lk_gnt=1` for 8 cycles.
  - Cycle 9: `lk_gnt=0` and one entry issues.
  - `starve_cnt` restarts.
- `lk_req=1` continuously with 4 pushes (DEPTH=4):
  - `upd_ready=0` once `pending=4`.
  - FORCE issues the head next cycle, `pending=3`.
  - `upd_ready=1` again the following cycle.
- Same-index ordering: push pc=9 as taken,not-taken,taken with `lk_req=0`. The table sees writes 1,0,1 on consecutive edges.
- Assert reset low mid-drain with `pending=3`:
  - Immediately `pending=0`, `upd_ready=1`, `tbl_read_only=1`.
  - No further table writes occur.
- With `LHT_HAZARD_STALL_EN`: FIFO holds pc=12, and `lk_req` is asserted with `lk_pc=12`.
  - Cycle 1: `lk_gnt=0` and pc=12 is issued.
  - Cycle 2: `lk_gnt=1`.
  - Without the macro, `lk_gnt=1` in cycle 1.
